// File: rtl/alu_sequencer.sv
// alu_sequencer: command sequencer for a shared 8-bit ALU datapath.
// Accepts one operation over a valid/ready command port, drives the ALU
// operand buses, captures the selected result and returns it over a
// valid/ready response port.
// Optional feature macro: ALU_SEQ_MUL_EN adds an 8x8 shift-add multiply
// (opcode 8) built from repeated passes through the ALU adder. Without it,
// opcode 8 is reported as illegal.
module alu_sequencer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [3:0] cmd_op_i,
  input  logic [7:0] cmd_a_i,
  input  logic [7:0] cmd_b_i,
  output logic [7:0] alu_in_a_o,
  output logic [7:0] alu_in_b_o,
  input  logic [7:0] alu_add_i,
  input  logic [7:0] alu_left_i,
  input  logic [7:0] alu_right_i,
  input  logic [7:0] alu_and_i,
  input  logic [7:0] alu_or_i,
  input  logic [7:0] alu_xor_i,
  input  logic [7:0] alu_nand_i,
  input  logic [7:0] alu_comp_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic [7:0] rsp_high_o,
  output logic       rsp_zero_o,
  output logic       rsp_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SHL  = 4'd1;
  localparam logic [3:0] OP_SHR  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_CMP  = 4'd7;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd8;
`endif

  // Zero detect on a 16-bit value (single-cycle results pass a zero high byte).
  function automatic logic is_zero16(input logic [15:0] v);
    return (v == 16'h0000);
  endfunction

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [7:0] rsp_high_q, rsp_high_d;
  logic       rsp_zero_q, rsp_zero_d;
  logic       rsp_err_q, rsp_err_d;

`ifdef ALU_SEQ_MUL_EN
  // P is the running high half, Q the multiplier shifting out into the low
  // half of the product; the multiplicand M is simply the latched operand A.
  logic [7:0] p_q, p_d;
  logic [7:0] q_q, q_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sum_s;
  logic       carry_s;
  logic [8:0] form_s;
`endif

  // Next-state, operand latching and result capture.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_high_d = rsp_high_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
`ifdef ALU_SEQ_MUL_EN
    p_d     = p_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    // ALU adder sees P + M; a wrapped sum means the 9th product bit is set.
    sum_s   = alu_add_i;
    carry_s = (sum_s < p_q);
    form_s  = q_q[0] ? {carry_s, sum_s} : {1'b0, p_q};
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          op_d = cmd_op_i;
          a_d  = cmd_a_i;
          b_d  = cmd_b_i;
`ifdef ALU_SEQ_MUL_EN
          if (cmd_op_i == OP_MUL) begin
            p_d     = 8'h00;
            q_d     = cmd_b_i;
            cnt_d   = 3'd0;
            state_d = ST_MUL;
          end else begin
            state_d = ST_EXEC;
          end
`else
          state_d = ST_EXEC;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_EXEC: begin
        rsp_high_d = 8'h00;
        rsp_err_d  = 1'b0;
        case (op_q)
          OP_ADD:  rsp_data_d = alu_add_i;
          OP_SHL:  rsp_data_d = alu_left_i;
          OP_SHR:  rsp_data_d = alu_right_i;
          OP_AND:  rsp_data_d = alu_and_i;
          OP_OR:   rsp_data_d = alu_or_i;
          OP_XOR:  rsp_data_d = alu_xor_i;
          OP_NAND: rsp_data_d = alu_nand_i;
          OP_CMP:  rsp_data_d = alu_comp_i;
          default: begin
            rsp_data_d = 8'h00;
            rsp_err_d  = 1'b1;
          end
        endcase
        rsp_zero_d = is_zero16({8'h00, rsp_data_d});
        state_d    = ST_RESP;
      end

`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        // Shift {form, Q} right by one into {P, Q}.
        p_d   = form_s[8:1];
        q_d   = {form_s[0], q_q[7:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          rsp_high_d = p_d;
          rsp_data_d = q_d;
          rsp_zero_d = is_zero16({p_d, q_d});
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else begin
          state_d = ST_MUL;
        end
      end
`endif

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and response registers; reset aborts any operation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      op_q       <= 4'h0;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      rsp_data_q <= 8'h00;
      rsp_high_q <= 8'h00;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_high_q <= rsp_high_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  // Multiply working registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q   <= 8'h00;
      q_q   <= 8'h00;
      cnt_q <= 3'd0;
    end else begin
      p_q   <= p_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign alu_in_a_o = (state_q == ST_MUL) ? p_q : a_q;
  assign alu_in_b_o = (state_q == ST_MUL) ? a_q : b_q;
`else
  assign alu_in_a_o = a_q;
  assign alu_in_b_o = b_q;
`endif

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_high_o  = rsp_high_q;
  assign rsp_zero_o  = rsp_zero_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
